euler_result_printer: RTL and testbench
=======================================

# euler_result_printer

Output side of the Euler problem engines. Accepts a one-cycle `results_valid`/`results` pulse from a solver such as `euler1`, converts the binary result to decimal, and streams it as ASCII characters over a valid/ready byte interface, terminated by a line feed. This gives benches and the board-level UART/console path the same decimal text that simulation prints.

## Interface
- `RESULT_W`, 24: width of the binary result.
- `DIGITS`, 8: decimal digit capacity; must satisfy 10^DIGITS > 2^RESULT_W - 1.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `results_valid`  in  1: one-cycle strobe; `results` is valid in the same cycle.
- `results`  in  RESULT_W: unsigned binary result.
- `busy`  out  1: high from the cycle after capture until the line feed is accepted.
- `char_valid`  out  1: ASCII byte available.
- `char_data`  out  8: ASCII byte.
- `char_ready`  in  1: consumer accepts the byte when `char_valid && char_ready` at a rising edge.
- `done`  out  1: one-cycle pulse in the cycle after the line feed is accepted.
- `overrun`  out  1: sticky; set when `results_valid` arrives while `busy`. Cleared only by reset.

## Operation
- States: IDLE, CONVERT, SKIP, SEND, EOL.
- IDLE: `busy`=0. When `results_valid`=1, capture `results`, clear the BCD register, go to CONVERT.
- CONVERT: iterative double-dabble, RESULT_W cycles, MSB first. Each cycle, add 3 to every BCD nibble that is ≥5, then shift left one bit with the next result bit. Then go to SKIP.
- SKIP: one cycle per check.
  - If the top digit is 0 and more than one digit remains: shift digits up and decrement the remaining count.
  - Otherwise go to SEND.
  - At least one digit is always sent, so a result of 0 prints "0".
- SEND: `char_valid`=1, `char_data` = 0x30 + top digit. On handshake, shift to the next digit. After the last digit is accepted, go to EOL.
- EOL: `char_valid`=1, `char_data`=0x0A. On handshake, pulse `done`, drop `busy`, return to IDLE.
- `results_valid` while `busy` is high: the value is dropped and `overrun` is set. The conversion in progress is unaffected.
- Arithmetic: BCD register is 4×DIGITS bits. No result is ever truncated, given the parameter constraint above.

## Timing
- Reset values: `busy`=0, `char_valid`=0, `char_data`=0x00, `done`=0, `overrun`=0; state is IDLE.
- Reset asserted mid-operation: all outputs clear immediately (asynchronous). The partial line is abandoned and no line feed is sent.
- Capture edge is cycle 0. CONVERT occupies cycles 1..RESULT_W. With z leading zeros, SKIP occupies z+1 cycles.
- First `char_valid` is asserted in cycle RESULT_W + z + 2.
- With `char_ready` held at 1: one character per cycle, and `done` is asserted one cycle after EOL.
- While `char_valid && !char_ready`: `char_data` is held stable and `char_valid` stays high. `char_valid` never drops without a handshake, except on reset.
- `results_valid` in the same cycle as the final EOL handshake is an overrun.
- `results_valid` in the `done` cycle is accepted, because `busy` is already 0.

## Structure
- Shared package `euler_pkg`:
  - `RESULT_W` default
  - `ASCII_ZERO` (0x30)
  - `ASCII_LF` (0x0A)
  - state encoding constants
- Sub-module `bin2bcd_seq`:
  - Interface: start, binary in, BCD out, done.
  - Contains the CONVERT counter and the add-3/shift datapath.
  - Reusable by later Euler problem blocks.
- The top level holds the FSM, digit shifter and handshake.

## Test plan
- `results`=233168, `char_ready`=1 → bytes "2","3","3","1","6","8",0x0A on consecutive cycles. First `char_valid` in cycle 28. `done` pulses once, then `busy`=0.
- `results`=0 → "0",0x0A. First `char_valid` in cycle 33.
- `results`=16777215 → "16777215",0x0A. First `char_valid` in cycle 26.
- `results`=233168 with `char_ready` toggling 1,0,0,1,… → identical byte sequence. `char_data` stays stable during every stall, and no bytes are duplicated or lost.
- Second `results_valid` at cycle 10 of a conversion → `overrun`=1 (sticky), and the first result still prints correctly. A new pulse in the `done` cycle prints normally.
- Reset pulled low mid-SEND → all outputs 0 within the same cycle. After release, a new result prints in full.

Source files
------------

// File: rtl/euler_pkg.sv
// Shared constants and types for the Euler problem output path.
// Holds default widths, ASCII codes and the printer state encoding.
package euler_pkg;

    localparam int DEFAULT_RESULT_W = 24;
    localparam int DEFAULT_DIGITS   = 8;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CONVERT = 3'd1,
        ST_SKIP    = 3'd2,
        ST_SEND    = 3'd3,
        ST_EOL     = 3'd4
    } state_e;

    function automatic logic [7:0] ascii_digit(input logic [3:0] d);
        return ASCII_ZERO + {4'h0, d};
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one result bit per cycle, MSB first.
// done_o is high during the cycle whose rising edge performs the final step.
module bin2bcd_seq #(
    parameter int BIN_W  = 24,
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [BIN_W-1:0]      bin_i,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  done_o
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    logic [BIN_W-1:0] bin_q;
    logic [BCD_W-1:0] bcd_q, bcd_d, adj;
    logic [CNT_W-1:0] cnt_q;
    logic             active_q;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_d = {adj[BCD_W-2:0], bin_q[BIN_W-1]};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (start_i) begin
            bin_q    <= bin_i;
            bcd_q    <= '0;
            cnt_q    <= CNT_W'(BIN_W);
            active_q <= 1'b1;
        end else if (active_q) begin
            bin_q <= bin_q << 1;
            bcd_q <= bcd_d;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                active_q <= 1'b0;
            end
        end
    end

    assign bcd_o  = bcd_q;
    assign done_o = active_q && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/euler_result_printer.sv
// Converts a solver result to decimal and streams it as ASCII bytes plus LF.
// Leading zeros are suppressed, but at least one digit is always printed.
module euler_result_printer
    import euler_pkg::*;
#(
    parameter int RESULT_W = DEFAULT_RESULT_W,
    parameter int DIGITS   = DEFAULT_DIGITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                results_valid,
    input  logic [RESULT_W-1:0] results,
    output logic                busy,
    output logic                char_valid,
    output logic [7:0]          char_data,
    input  logic                char_ready,
    output logic                done,
    output logic                overrun
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int REM_W = $clog2(DIGITS + 1);

    state_e           state_q, state_d;
    logic [BCD_W-1:0] digits_q, digits_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic             first_q;
    logic             done_q, done_d;
    logic             overrun_q;

    logic             capture, conv_done, char_fire, skip_zero;
    logic [BCD_W-1:0] bcd, skip_src;

    assign capture   = (state_q == ST_IDLE) && results_valid;
    assign char_fire = char_valid && char_ready;

    // The converter result lands on the same edge that enters SKIP, so the first
    // SKIP cycle reads it directly instead of waiting for a copy.
    assign skip_src  = first_q ? bcd : digits_q;
    assign skip_zero = (skip_src[BCD_W-1 -: 4] == 4'd0) && (rem_q > REM_W'(1));

    bin2bcd_seq #(
        .BIN_W  (RESULT_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk     (clk),
        .rst_n   (reset),
        .start_i (capture),
        .bin_i   (results),
        .bcd_o   (bcd),
        .done_o  (conv_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (results_valid)                      state_d = ST_CONVERT;
            ST_CONVERT: if (conv_done)                          state_d = ST_SKIP;
            ST_SKIP:    if (!skip_zero)                         state_d = ST_SEND;
            ST_SEND:    if (char_fire && rem_q == REM_W'(1))    state_d = ST_EOL;
            ST_EOL:     if (char_fire)                          state_d = ST_IDLE;
            default:                                            state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q != ST_IDLE);
        char_valid = (state_q == ST_SEND) || (state_q == ST_EOL);
        char_data  = 8'h00;
        if (state_q == ST_SEND) begin
            char_data = ascii_digit(digits_q[BCD_W-1 -: 4]);
        end else if (state_q == ST_EOL) begin
            char_data = ASCII_LF;
        end
        done    = done_q;
        overrun = overrun_q;
    end

    always_comb begin
        digits_d = digits_q;
        rem_d    = rem_q;
        done_d   = (state_q == ST_EOL) && char_fire;
        unique case (state_q)
            ST_CONVERT: rem_d = REM_W'(DIGITS);
            ST_SKIP: begin
                if (skip_zero) begin
                    digits_d = skip_src << 4;
                    rem_d    = rem_q - REM_W'(1);
                end else begin
                    digits_d = skip_src;
                end
            end
            ST_SEND: begin
                if (char_fire) begin
                    digits_d = digits_q << 4;
                    rem_d    = rem_q - REM_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digits_q  <= '0;
            rem_q     <= '0;
            first_q   <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            digits_q  <= digits_d;
            rem_q     <= rem_d;
            first_q   <= conv_done;
            done_q    <= done_d;
            overrun_q <= overrun_q | (results_valid && busy);
        end
    end

endmodule

// File: tb/tb_euler_result_printer.sv
// Scoreboard bench for euler_result_printer: stimulus pushes expected bytes and
// first-valid cycles; a negedge monitor pops and compares on every handshake.
module tb_euler_result_printer;
    import euler_pkg::*;

    localparam int RW = 24;

    logic          clk;
    logic          rst_n;
    logic          results_valid;
    logic [RW-1:0] results;
    logic          busy;
    logic          char_valid;
    logic [7:0]    char_data;
    logic          char_ready;
    logic          done;
    logic          overrun;

    euler_result_printer #(.RESULT_W(RW), .DIGITS(8)) dut (
        .clk           (clk),
        .reset         (rst_n),
        .results_valid (results_valid),
        .results       (results),
        .busy          (busy),
        .char_valid    (char_valid),
        .char_data     (char_data),
        .char_ready    (char_ready),
        .done          (done),
        .overrun       (overrun)
    );

    typedef struct {
        int unsigned value;
        string       text;
        int          first;
    } vec_t;

    vec_t       vecs[3];
    logic [7:0] exp_q[$];
    int         exp_first_q[$];
    int         total = 0;
    int         bad   = 0;
    int         edge_n = 0;
    bit         ready_mode = 0;
    int         rphase = 0;
    bit         lf_prev = 0;
    bit         prev_stall = 0;
    bit         prev_valid = 0;
    logic [7:0] stall_data = 8'h00;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_n++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at edge %0d",
                     name, act, act, exp, exp, edge_n);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s at edge %0d", name, edge_n);
    endtask

    // char_ready: held high, or the 1,0,0 repeating pattern.
    initial begin
        char_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode) begin
                char_ready = (rphase == 0);
                rphase     = (rphase + 1) % 3;
            end else begin
                char_ready = 1'b1;
            end
        end
    end

    // Monitor: everything sampled at negedge, away from the active edge.
    initial begin
        logic [7:0] exp_b;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                lf_prev    = 0;
                prev_stall = 0;
                prev_valid = 0;
            end else begin
                if (lf_prev || done) begin
                    check("done_pulse", {31'd0, done}, {31'd0, lf_prev});
                    if (lf_prev) check("busy_in_done_cycle", {31'd0, busy}, 32'd0);
                end
                if (prev_stall) begin
                    check("stall_valid", {31'd0, char_valid}, 32'd1);
                    check("stall_data", {24'd0, char_data}, {24'd0, stall_data});
                end
                if (char_valid && !prev_valid) begin
                    if (exp_first_q.size() > 0) check("first_valid_cycle", edge_n + 1, exp_first_q.pop_front());
                    else fail_now("unexpected_char_valid");
                end
                lf_prev = 0;
                if (char_valid && char_ready) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_byte");
                    end else begin
                        exp_b = exp_q.pop_front();
                        check("char", {24'd0, char_data}, {24'd0, exp_b});
                        if (exp_b == ASCII_LF) lf_prev = 1;
                    end
                end
                prev_stall = char_valid && !char_ready;
                stall_data = char_data;
                prev_valid = char_valid;
            end
        end
    end

    task automatic push_expected(input int idx, input int cap);
        for (int i = 0; i < vecs[idx].text.len(); i++) exp_q.push_back(vecs[idx].text[i]);
        exp_q.push_back(ASCII_LF);
        exp_first_q.push_back(cap + vecs[idx].first);
    endtask

    // Drive a one-cycle strobe; it is sampled at the next rising edge.
    task automatic pulse(input int unsigned value);
        results_valid = 1'b1;
        results       = RW'(value);
        @(posedge clk);
        #1;
        results_valid = 1'b0;
    endtask

    task automatic send_result(input int idx);
        @(posedge clk);
        #1;
        push_expected(idx, edge_n + 1);
        pulse(vecs[idx].value);
    endtask

    task automatic send_on_done(input int idx);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done && n < 300);
        if (!done) fail_now("timeout_waiting_done");
        push_expected(idx, edge_n + 1);
        pulse(vecs[idx].value);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_q.size() != 0 || busy) && n < 400);
        if (n >= 400) fail_now("timeout_waiting_idle");
        repeat (2) @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{value: 233168,   text: "233168",   first: 28};
        vecs[1] = '{value: 0,        text: "0",        first: 33};
        vecs[2] = '{value: 16777215, text: "16777215", first: 26};

        rst_n         = 1'b0;
        results_valid = 1'b0;
        results       = '0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_char_valid", {31'd0, char_valid}, 32'd0);
        check("reset_char_data", {24'd0, char_data}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_overrun", {31'd0, overrun}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Straight printing with char_ready held high.
        for (int v = 0; v < 3; v++) begin
            send_result(v);
            wait_idle();
        end

        // Same value with a stalling consumer.
        ready_mode = 1;
        send_result(0);
        wait_idle();
        ready_mode = 0;

        // Overrun during conversion, then a new strobe in the done cycle.
        check("overrun_before", {31'd0, overrun}, 32'd0);
        send_result(0);
        repeat (8) @(posedge clk);
        #1;
        pulse(999);
        check("overrun_set", {31'd0, overrun}, 32'd1);
        send_on_done(2);
        wait_idle();
        check("overrun_sticky", {31'd0, overrun}, 32'd1);

        // Reset in the middle of SEND.
        send_result(2);
        begin
            int n;
            n = 0;
            do begin
                @(posedge clk);
                #1;
                n++;
            end while (!char_valid && n < 100);
            if (!char_valid) fail_now("timeout_waiting_send");
        end
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_first_q.delete();
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_char_valid", {31'd0, char_valid}, 32'd0);
        check("midreset_char_data", {24'd0, char_data}, 32'd0);
        check("midreset_done", {31'd0, done}, 32'd0);
        check("midreset_overrun", {31'd0, overrun}, 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        send_result(0);
        wait_idle();

        check("queue_drained", exp_q.size(), 32'd0);
        check("first_queue_drained", exp_first_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout at edge %0d", edge_n);
        $fatal(1, "global timeout");
    end

endmodule
